alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 98 +++++++++
 tb/tb_alu_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters via an IDLE/EXEC/RESP handshake.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [17:0] req0_cntl,
    input  logic [31:0] req0_opnd0,
    input  logic [31:0] req0_opnd1,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [17:0] req1_cntl,
    input  logic [31:0] req1_opnd0,
    input  logic [31:0] req1_opnd1,
    output logic [17:0] alu_cntl,
    output logic [31:0] alu_opnd0,
    output logic [31:0] alu_opnd1,
    output logic [6:0]  alu_status_in,
    input  logic [31:0] alu_result,
    input  logic [6:0]  alu_status_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [6:0]  rsp_status,
    input  logic        status_ld,
    input  logic [6:0]  status_ld_val,
    input  logic        flush,
    output logic [6:0]  status
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      state;
    logic [17:0] op_cntl;
    logic [31:0] op_opnd0, op_opnd1;
    logic        op_id;
    logic [6:0]  status_q;
    logic        grant, accept, exec;
`ifdef ALU_ARB_RR_EN
    logic ptr;
    assign grant = ptr ? (req1_valid | ~req0_valid) : (~req0_valid & req1_valid);
`else
    assign grant = ~req0_valid & req1_valid;
`endif
    // flush and reset both block acceptance so no handshake is silently dropped
    assign req0_ready    = (state == IDLE) & ~flush & ~rst & ~grant;
    assign req1_ready    = (state == IDLE) & ~flush & ~rst & grant;
    assign accept        = (req0_valid & req0_ready) | (req1_valid & req1_ready);
    assign exec          = state == EXEC;
    assign alu_cntl      = exec ? op_cntl : 18'b0;
    assign alu_opnd0     = exec ? op_opnd0 : 32'b0;
    assign alu_opnd1     = exec ? op_opnd1 : 32'b0;
    assign alu_status_in = status_q;
    assign rsp_valid     = state == RESP;
    assign status        = status_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            status_q   <= 7'b0;
            op_cntl    <= 18'b0;
            op_opnd0   <= 32'b0;
            op_opnd1   <= 32'b0;
            op_id      <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= 32'b0;
            rsp_status <= 7'b0;
`ifdef ALU_ARB_RR_EN
            ptr        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_cntl  <= grant ? req1_cntl : req0_cntl;
                    op_opnd0 <= grant ? req1_opnd0 : req0_opnd0;
                    op_opnd1 <= grant ? req1_opnd1 : req0_opnd1;
                    op_id    <= grant;
                    state    <= EXEC;
`ifdef ALU_ARB_RR_EN
                    ptr      <= ~grant;
`endif
                end
                EXEC: if (flush) state <= IDLE;
                else begin
                    rsp_result <= alu_result;
                    rsp_status <= alu_status_out;
                    rsp_id     <= op_id;
                    status_q   <= alu_status_out;
                    state      <= RESP;
                end
                RESP: if (flush | rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
            // a direct flag load overrides the ALU flag capture of the same cycle
            if (status_ld) status_q <= status_ld_val;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
module tb_alu_arbiter;
    logic        clk = 0, rst = 0;
    logic        req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
    logic [17:0] req0_cntl = 0, req1_cntl = 0, alu_cntl;
    logic [31:0] req0_opnd0 = 0, req0_opnd1 = 0, req1_opnd0 = 0, req1_opnd1 = 0;
    logic [31:0] alu_opnd0, alu_opnd1, alu_result, rsp_result;
    logic [6:0]  alu_status_in, alu_status_out, rsp_status, status, status_ld_val = 0;
    logic        rsp_valid, rsp_ready = 0, rsp_id, status_ld = 0, flush = 0;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cntl(req0_cntl),
        .req0_opnd0(req0_opnd0), .req0_opnd1(req0_opnd1),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cntl(req1_cntl),
        .req1_opnd0(req1_opnd0), .req1_opnd1(req1_opnd1),
        .alu_cntl(alu_cntl), .alu_opnd0(alu_opnd0), .alu_opnd1(alu_opnd1),
        .alu_status_in(alu_status_in), .alu_result(alu_result), .alu_status_out(alu_status_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_status(rsp_status),
        .status_ld(status_ld), .status_ld_val(status_ld_val), .flush(flush), .status(status)
    );

    // environment ALU: {status[6:0], result[31:0]}; low flags mix incoming flags with cntl[17:14]
    function automatic logic [38:0] alu_fn(input logic [17:0] c, input logic [31:0] a, input logic [31:0] b,
                                           input logic [6:0] s);
        logic [32:0] r;
        r = c[1:0] == 2'd0 ? {1'b0, a} + {1'b0, b} :
            c[1:0] == 2'd1 ? {1'b0, a} - {1'b0, b} :
            c[1:0] == 2'd2 ? {1'b0, a & b} : {1'b0, a ^ b};
        return {r[31:0] == 32'b0, r[31], r[32], s[3:0] ^ c[17:14], r[31:0]};
    endfunction

    assign {alu_status_out, alu_result} = alu_fn(alu_cntl, alu_opnd0, alu_opnd1, alu_status_in);

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // requester side: a pending request is held unchanged until accepted
    bit          pend [2];
    logic [17:0] pc [2];
    logic [31:0] pa [2], pb [2];
    bit          ids [$];

    task automatic set_req(input int i, input logic [17:0] c, input logic [31:0] a, input logic [31:0] b);
        pend[i] = 1; pc[i] = c; pa[i] = a; pb[i] = b;
    endtask

    // model: at most one op in flight; age 1 = at the ALU, age 2 = response offered
    bit          synced = 0, m_busy = 0, m_id = 0, m_ptr = 0;
    int          m_age = 0;
    logic [81:0] m_op = 0;
    logic [39:0] m_rsp = 0;
    logic [6:0]  m_st = 0;

    task automatic tick();
        bit w, go;
        logic [38:0] a;
        req0_valid = pend[0]; req0_cntl = pc[0]; req0_opnd0 = pa[0]; req0_opnd1 = pb[0];
        req1_valid = pend[1]; req1_cntl = pc[1]; req1_opnd0 = pa[1]; req1_opnd1 = pb[1];
        #1;
`ifdef ALU_ARB_RR_EN
        w = (pend[0] && pend[1]) ? m_ptr : pend[1];
`else
        w = pend[1] && !pend[0];
`endif
        go = synced && !m_busy && !flush && !rst && (pend[0] || pend[1]);
        if (synced) begin
            check("acc0", req0_valid & req0_ready, go && !w);
            check("acc1", req1_valid & req1_ready, go && w);
            if (m_busy || flush || rst) check("ready_blocked", {req0_ready, req1_ready}, 0);
            check("alu_drive", {alu_cntl, alu_opnd0, alu_opnd1}, (m_busy && m_age == 1) ? m_op : 82'b0);
            if (m_busy && m_age == 1) check("alu_status_in", alu_status_in, m_st);
            check("rsp_valid", rsp_valid, m_busy && m_age == 2);
            if (m_busy && m_age == 2) check("rsp_data", {rsp_id, rsp_status, rsp_result}, m_rsp);
            check("status", status, m_st);
        end
        if (rsp_valid && rsp_ready) ids.push_back(rsp_id);
        if (rst) begin
            synced = 1; m_busy = 0; m_st = 0; m_ptr = 0;
        end else if (synced) begin
            if (!m_busy) begin
                if (go) begin
                    m_busy = 1; m_age = 1; m_id = w; m_op = {pc[w], pa[w], pb[w]}; m_ptr = !w; pend[w] = 0;
                end
            end else if (m_age == 1) begin
                if (flush) m_busy = 0;
                else begin
                    a = alu_fn(m_op[81:64], m_op[63:32], m_op[31:0], m_st);
                    m_rsp = {m_id, a}; m_st = a[38:32]; m_age = 2;
                end
            end else if (flush || rsp_ready) m_busy = 0;
            if (status_ld) m_st = status_ld_val;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        #1 check("reset_ready0", req0_ready, 1);
        tick();
        // single ADD 5+7
        set_req(0, 18'h0, 32'd5, 32'd7); rsp_ready = 1;
        repeat (2) tick();
        #1 check("single_add", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 32'd12});
        repeat (2) tick();
        // contention from a fresh reset
        do_reset();
        ids.delete();
        for (int i = 0; i < 12; i++) begin
            for (int p = 0; p < 2; p++) if (!pend[p]) set_req(p, 18'h0, 32'(i), 32'(p));
            tick();
        end
        pend[0] = 0; pend[1] = 0;
        check("contention_count", ids.size(), 4);
        for (int i = 0; i < 4; i++)
`ifdef ALU_ARB_RR_EN
            if (i < ids.size()) check("contention_id", ids[i], i % 2);
`else
            if (i < ids.size()) check("contention_id", ids[i], 0);
`endif
        tick();
        // backpressure
        set_req(1, 18'h3, 32'hdead_beef, 32'h1234_5678); rsp_ready = 0;
        repeat (8) tick();
        rsp_ready = 1; repeat (2) tick();
        // flush during EXEC of SUB 1-1
        do_reset();
        set_req(0, 18'h1, 32'd1, 32'd1); tick();
        flush = 1; tick(); flush = 0;
        #1 check("flush_zf", {rsp_valid, status[6]}, 0);
        tick();
        set_req(0, 18'h1, 32'd1, 32'd1); repeat (4) tick();
        // flag load coincident with capture
        do_reset();
        set_req(0, 18'h28000, 32'd3, 32'd4); tick();
        status_ld = 1; status_ld_val = 7'h55; tick(); status_ld = 0;
        #1 check("ld_vs_capture", {status, rsp_status, rsp_result}, {7'h55, 7'h0a, 32'd7});
        tick();
        // reset while a response is pending
        set_req(0, 18'h2, 32'hff, 32'h0f); rsp_ready = 0; repeat (2) tick();
        #1 check("resp_before_rst", rsp_valid, 1);
        do_reset();
        #1 check("after_rst", {rsp_valid, status, req0_ready}, {1'b0, 7'h0, 1'b1});
        tick();
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(2) == 0) set_req(p, 18'($urandom), $urandom, $urandom);
            rsp_ready = $urandom_range(3) != 0;
            flush = $urandom_range(19) == 0;
            status_ld = $urandom_range(9) == 0;
            status_ld_val = 7'($urandom);
            rst = $urandom_range(99) == 0;
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
